// File: rtl/pulse_cdc_scheduler.sv
// rtl/pulse_cdc_scheduler.sv - shares one toggle pulse synchronizer among N_REQ sources with GAP-cycle spacing.
// Define PULSE_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pulse_cdc_scheduler #(
  parameter int N_REQ = 4,
  parameter int GAP   = 8,
  parameter int IDW   = 2
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             clr_ovf,
  output logic             sync_pulse,
  output logic [IDW-1:0]   sync_id,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] ovf,
  output logic             busy
);

  localparam int CW = $clog2(GAP);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] pend_d, ovf_d, grant_vec;
  logic             pulse_d, issue, found;
  logic [IDW-1:0]   id_d, winner;

`ifdef PULSE_SCHED_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] upper;

  // Prefer the lowest pending index at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = pend[i] && (i >= int'(ptr_q));
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend[i] && (upper == '0)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (upper[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      if (winner == IDW'(N_REQ - 1)) ptr_d = '0;
      else                           ptr_d = winner + 1'b1;
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign issue = (state_q == S_IDLE) && en && found;

  always_comb begin
    grant_vec = '0;
    if (issue) grant_vec = N_REQ'(1) << winner;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    id_d    = sync_id;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          pulse_d = 1'b1;
          id_d    = winner;
          cnt_d   = CW'(GAP - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) state_d = S_IDLE;
      end
    endcase
  end

  // A request landing on the granted source is a fresh event; on any other pending source it merges.
  always_comb begin
    pend_d = (pend & ~grant_vec) | req;
    ovf_d  = (clr_ovf ? '0 : ovf) | (req & pend & ~grant_vec);
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sync_pulse <= 1'b0;
      sync_id    <= '0;
      pend       <= '0;
      ovf        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_pulse <= pulse_d;
      sync_id    <= id_d;
      pend       <= pend_d;
      ovf        <= ovf_d;
    end
  end

  assign busy = (state_q == S_GAP);

endmodule

// File: tb/tb_pulse_cdc_scheduler.sv
// tb/tb_pulse_cdc_scheduler.sv - randomized scoreboard bench for pulse_cdc_scheduler.
module tb_pulse_cdc_scheduler;
  localparam int N = 4;
  localparam int G = 8;
  localparam int W = 2;

  logic         clk_fast = 1'b0;
  logic         rst_n    = 1'b0;
  logic         en       = 1'b0;
  logic         clr_ovf  = 1'b0;
  logic [N-1:0] req      = '0;
  logic         sync_pulse;
  logic [W-1:0] sync_id;
  logic [N-1:0] pend;
  logic [N-1:0] ovf;
  logic         busy;

  pulse_cdc_scheduler #(.N_REQ(N), .GAP(G), .IDW(W)) dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .en(en), .req(req), .clr_ovf(clr_ovf),
    .sync_pulse(sync_pulse), .sync_id(sync_id), .pend(pend), .ovf(ovf), .busy(busy)
  );

  always #5 clk_fast = ~clk_fast;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  int m_pend[N];
  int m_ovf[N];
  int m_ptr, m_since, m_id, m_pulse, m_g, m_k;
  int cyc = 0;
  int last_pulse = -1000;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: a source may be issued once GAP cycles have elapsed since the last issue.
  always @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_ovf[i]  = 0;
      end
      m_ptr = 0; m_since = G; m_id = 0; m_pulse = 0;
      exp_q.delete();
    end else begin
      m_g = -1;
      if (en && m_since >= G - 1) begin
        for (int j = 0; j < N; j++) begin
`ifdef PULSE_SCHED_FIXED_PRIO_EN
          m_k = j;
`else
          m_k = (m_ptr + j) % N;
`endif
          if (m_g < 0 && m_pend[m_k] != 0) m_g = m_k;
        end
      end
      if (clr_ovf) for (int i = 0; i < N; i++) m_ovf[i] = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_pend[i] != 0 && i != m_g) m_ovf[i] = 1;
          m_pend[i] = 1;
        end else if (i == m_g) begin
          m_pend[i] = 0;
        end
      end
      if (m_g >= 0) begin
        m_id = m_g; m_ptr = (m_g + 1) % N; m_since = 0; m_pulse = 1;
        exp_q.push_back(m_g);
      end else begin
        m_pulse = 0;
        if (m_since < G) m_since++;
      end
    end
  end

  always @(posedge clk_fast) cyc++;

  // Monitor: compares every registered output, pops the scoreboard on each issued pulse.
  always @(negedge clk_fast) begin
    int mp, mo;
    if (rst_n) begin
      mp = 0; mo = 0;
      for (int i = 0; i < N; i++) begin
        mp += m_pend[i] << i;
        mo += m_ovf[i] << i;
      end
      chk("pend", int'(pend), mp);
      chk("ovf", int'(ovf), mo);
      chk("busy", int'(busy), (m_since < G - 1) ? 1 : 0);
      chk("sync_id_hold", int'(sync_id), m_id);
      chk("sync_pulse", int'(sync_pulse), m_pulse);
      if (sync_pulse) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
        else chk("pulse_id", int'(sync_id), exp_q.pop_front());
        checks++;
        if (cyc - last_pulse < G) begin
          errors++;
          $display("FAIL pulse_spacing: got %0d expected >= %0d", cyc - last_pulse, G);
        end
        last_pulse = cyc;
      end
    end else begin
      last_pulse = -1000;
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic e, input logic c);
    @(posedge clk_fast);
    #1;
    req = r; en = e; clr_ovf = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk_fast);
    #1;
    rst_n = 1'b1;
    chk("rst_sync_pulse", int'(sync_pulse), 0);
    chk("rst_sync_id", int'(sync_id), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    idle(6);

    drive(4'b0001, 1'b1, 1'b0);
    idle(14);

    drive(4'b1111, 1'b1, 1'b0);
    idle(40);

    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    idle(20);
    chk("ovf_merge", int'(ovf), 4);
    drive(4'b0000, 1'b1, 1'b1);
    idle(2);
    chk("ovf_clear", int'(ovf), 0);
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b1);
    idle(20);
    chk("ovf_set_wins", int'(ovf), 4);
    drive(4'b0000, 1'b1, 1'b1);
    idle(4);

    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    idle(24);
    chk("collision_ovf", int'(ovf), 0);

    drive(4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) drive('0, 1'b0, 1'b0);
    chk("en_hold_pend", int'(pend), 3);
    idle(24);

    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0110, 1'b1, 1'b0);
    idle(3);
    @(posedge clk_fast);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sync_pulse", int'(sync_pulse), 0);
    chk("arst_sync_id", int'(sync_id), 0);
    chk("arst_pend", int'(pend), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_busy", int'(busy), 0);
    repeat (2) @(posedge clk_fast);
    #1;
    rst_n = 1'b1;
    idle(20);

    for (int i = 0; i < 500; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drive(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end
    idle(80);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
